io_sys_update_emu: RTL
======================

Name: io_sys_update_emu

Overview:
- Synthesizable responder for the remote-system-update parameter interface: read_param/write_param/param/read_source/data_in/data_out/busy/reconfig/reset_timer.
- Drop-in stand-in for the vendor RSU IP on boards or simulation models that lack it, so the IO-side RSU controllers run unchanged.
- Holds the current, previous-1, previous-2 and input (staged) parameter sets.
- Emulates a user-triggered reconfiguration and a watchdog-triggered fallback to factory, with busy handshaking.

Parameters:
- CBusyLat, 4: busy cycles after each accepted access or reconfig; legal range 1..15.
- CBootAddrFact, 32'h00000000: factory boot address loaded at reset and on watchdog fallback.
- CWdShift, 8: watchdog counter tick = timeout value << CWdShift cycles.

Ports:
- AClkH  in  1  clock; all logic on rising edge.
- AResetH  in  1  reset, synchronous, active-high.
- ARdParam  in  1  read request (level, sampled when not busy).
- AWrParam  in  1  write request (level, sampled when not busy).
- AParam  in  3  parameter select.
- ASrc  in  2  read source: 0 current, 1 previous-1, 2 input, 3 previous-2.
- ADataIn  in  32  write data.
- ADataOut  out  32  read data, zero-extended.
- ABusy  out  1  busy.
- AReconfig  in  1  reconfig trigger (rising edge).
- AResetTimer  in  1  watchdog kick (level high clears counter).
- AReconfigReq  out  1  one-cycle pulse when a reconfiguration is emulated.
- AWdTimeout  out  1  one-cycle pulse on watchdog expiry.
- ABootAddr  out  32  boot address of the current set.

Behaviour:
- Parameter set fields and write widths:
  - P0: cause, 5b, read-only.
  - P2: wd timeout, 12b, from ADataIn[11:0].
  - P3: wd enable, 1b, from [0].
  - P4: boot address, 32b, from [31:0].
  - P5: mode, 2b, from [1:0]; 0 = factory, 1 = application.
  - P1, P6, P7: read 0; writes ignored.
- Writes go only to the input set. Reads select the set by ASrc.
- Reset state:
  - All sets: addr = CBootAddrFact, mode 0, wd timeout 0, wd enable 0, cause 0.
  - Busy counter 0, watchdog counter 0, pending-reconfig flag 0.
  - Outputs: ADataOut 0, AReconfigReq 0, AWdTimeout 0, ABootAddr = CBootAddrFact.
  - ABusy = ARdParam | AWrParam, the combinational term only.
- Handshake:
  - ABusy = (FBusyCnt != 0) | (idle & (ARdParam | AWrParam)). Busy is therefore visible in the request cycle.
  - Request accepted in a cycle where FBusyCnt == 0. On acceptance FBusyCnt <= CBusyLat.
  - Read: ADataOut is registered at acceptance and held stable until the next accepted read. It is valid by the first cycle ABusy is low.
  - Write: the input-set field updates at acceptance.
  - Requests while FBusyCnt != 0 are ignored. The requester holds the request level until busy falls, or re-issues it.
  - ARdParam and AWrParam together: the write is performed and the read is ignored. ADataOut is unchanged.
- Reconfig:
  - A rising edge of AReconfig sets the pending flag.
  - When pending and FBusyCnt == 0, in a single cycle:
    - prev2 <= prev1, prev1 <= current.
    - current <= input set with mode forced to 1 and cause = 5'h01.
    - AReconfigReq pulses.
    - FBusyCnt <= CBusyLat; watchdog counter cleared; pending cleared.
  - A pending reconfig has priority over a simultaneous read or write; the access is ignored.
  - Edges arriving while pending are merged.
- Watchdog:
  - Active only when current.wd enable = 1 and current.mode = 1.
  - Counter width 12 + CWdShift bits. It increments each cycle and is cleared while AResetTimer = 1.
  - Expiry occurs when counter == {wd timeout, CWdShift zeros} and the timeout is nonzero. A timeout of 0 disables the watchdog.
  - Expiry actions:
    - prev shift as for reconfig.
    - current <= factory (CBootAddrFact, mode 0, wd off) with cause = 5'h04.
    - AWdTimeout and AReconfigReq pulse.
    - FBusyCnt <= CBusyLat.
  - Expiry in the same cycle as a pending user reconfig: the watchdog wins and the pending flag is cleared.
- ABootAddr = current.addr, registered.
- Reset asserted mid-access or mid-busy: everything returns to reset state the next edge; no pulses emitted.

Decomposition:
- Shared package io_sys_update_pkg:
  - Param index constants (IParCause = 0, IParWdVal = 2, IParWdEn = 3, IParAddr = 4, IParMode = 5).
  - Source codes (ISrcCur, ISrcPrev1, ISrcInput, ISrcPrev2).
  - Cause codes (CCauseUser = 5'h01, CCauseWd = 5'h04).
  - Packed struct for one parameter set (cause, wd_val, wd_en, addr, mode).
- One sub-module, io_sys_update_emu_wdt: watchdog counter with enable, clear, timeout value, shift; single-cycle expiry output.

Test Plan:
- Reset, then read P5 (ASrc = 0) -> ABusy high in the request cycle and 4 cycles after; ADataOut = 0. Read P4 -> ADataOut = CBootAddrFact.
- Write P4 = 32'h00A00000, read P4 with ASrc = 2 -> ADataOut = 32'h00A00000. The same read with ASrc = 0 -> CBootAddrFact.
- Pulse AReconfig -> AReconfigReq one cycle; ABootAddr = 32'h00A00000. Read P5 src 0 -> 1; P0 src 0 -> 1; P5 src 1 -> 0.
- Write P2 = 3, P3 = 1, reconfig, then no kicks with CWdShift = 8 -> AWdTimeout pulses 768 cycles after reconfig (±1). ABootAddr returns to factory; P0 src 0 = 4.
- Same setup but AResetTimer pulsed every 500 cycles -> no AWdTimeout over 5000 cycles.
- Simultaneous ARdParam + AWrParam on P4 = 32'h12345678, and a reconfig edge during busy -> write lands, ADataOut unchanged, reconfig executes only after busy falls. Assert AResetH mid-busy -> ABusy low after the next edge and state is reset.

Source files
------------

// File: rtl/io_sys_update_pkg.sv
// rtl/io_sys_update_pkg.sv - shared types and constants for the remote-update parameter emulator
package io_sys_update_pkg;

    // Parameter select codes
    localparam logic [2:0] IParCause = 3'd0;
    localparam logic [2:0] IParWdVal = 3'd2;
    localparam logic [2:0] IParWdEn  = 3'd3;
    localparam logic [2:0] IParAddr  = 3'd4;
    localparam logic [2:0] IParMode  = 3'd5;

    // Read source codes
    localparam logic [1:0] ISrcCur   = 2'd0;
    localparam logic [1:0] ISrcPrev1 = 2'd1;
    localparam logic [1:0] ISrcInput = 2'd2;
    localparam logic [1:0] ISrcPrev2 = 2'd3;

    // Reconfiguration cause codes
    localparam logic [4:0] CCauseUser = 5'h01;
    localparam logic [4:0] CCauseWd   = 5'h04;

    localparam logic [1:0] CModeFactory = 2'd0;
    localparam logic [1:0] CModeApp     = 2'd1;

    typedef struct packed {
        logic [4:0]  cause;
        logic [11:0] wd_val;
        logic        wd_en;
        logic [31:0] addr;
        logic [1:0]  mode;
    } param_set_t;

    // Factory image description with a given boot address and cause
    function automatic param_set_t factory_set(input logic [31:0] addr, input logic [4:0] cause);
        param_set_t s;
        s.cause  = cause;
        s.wd_val = 12'd0;
        s.wd_en  = 1'b0;
        s.addr   = addr;
        s.mode   = CModeFactory;
        return s;
    endfunction

    // Zero-extended view of one field; unused selects read as zero
    function automatic logic [31:0] field_read(input param_set_t s, input logic [2:0] p);
        logic [31:0] r;
        r = '0;
        case (p)
            IParCause: r = {27'd0, s.cause};
            IParWdVal: r = {20'd0, s.wd_val};
            IParWdEn:  r = {31'd0, s.wd_en};
            IParAddr:  r = s.addr;
            IParMode:  r = {30'd0, s.mode};
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/io_sys_update_emu_wdt.sv
// rtl/io_sys_update_emu_wdt.sv - watchdog counter with kick, restart and single-cycle expiry
module io_sys_update_emu_wdt #(
    parameter int CWdShift = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [11:0] val_i,
    output logic        expire_o
);

    localparam int CW = 12 + CWdShift;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A zero timeout disables expiry entirely
    assign expire_o = en_i & (val_i != 12'd0) & (cnt_q == {val_i, {CWdShift{1'b0}}});

    // Count while enabled; kick, restart or expiry returns the counter to zero
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_sys_update_emu.sv
// rtl/io_sys_update_emu.sv - remote-system-update parameter responder with reconfig and watchdog emulation
module io_sys_update_emu
    import io_sys_update_pkg::*;
#(
    parameter int unsigned CBusyLat      = 4,
    parameter logic [31:0] CBootAddrFact = 32'h0000_0000,
    parameter int          CWdShift      = 8
) (
    input  logic        AClkH,
    input  logic        AResetH,
    input  logic        ARdParam,
    input  logic        AWrParam,
    input  logic [2:0]  AParam,
    input  logic [1:0]  ASrc,
    input  logic [31:0] ADataIn,
    output logic [31:0] ADataOut,
    output logic        ABusy,
    input  logic        AReconfig,
    input  logic        AResetTimer,
    output logic        AReconfigReq,
    output logic        AWdTimeout,
    output logic [31:0] ABootAddr
);

    localparam logic [3:0] BusyLat = 4'(CBusyLat);

    param_set_t cur_q, cur_d;
    param_set_t prev1_q, prev1_d;
    param_set_t prev2_q, prev2_d;
    param_set_t inp_q, inp_d;
    param_set_t src_set;

    logic [3:0]  busy_cnt_q, busy_cnt_d;
    logic        pend_q, pend_d;
    logic        recfg_prev_q;
    logic [31:0] data_out_q, data_out_d;
    logic        req_q, wdto_q;
    logic [31:0] boot_addr_q;

    logic idle;
    logic recfg_rise;
    logic wd_active;
    logic wd_fire;
    logic user_fire;
    logic acc_ok;
    logic wr_go;
    logic rd_go;

    assign idle       = (busy_cnt_q == 4'd0);
    assign recfg_rise = AReconfig & ~recfg_prev_q;
    assign wd_active  = cur_q.wd_en & (cur_q.mode == CModeApp);
    // Watchdog beats a pending user reconfig; either one beats a host access
    assign user_fire  = pend_q & idle & ~wd_fire;
    assign acc_ok     = idle & ~pend_q & ~wd_fire;
    assign wr_go      = acc_ok & AWrParam;
    assign rd_go      = acc_ok & ARdParam & ~AWrParam;

    assign ABusy        = ~idle | (ARdParam | AWrParam);
    assign ADataOut     = data_out_q;
    assign AReconfigReq = req_q;
    assign AWdTimeout   = wdto_q;
    assign ABootAddr    = boot_addr_q;

    io_sys_update_emu_wdt #(
        .CWdShift (CWdShift)
    ) u_wdt (
        .clk_i    (AClkH),
        .rst_i    (AResetH),
        .en_i     (wd_active),
        .clr_i    (AResetTimer | user_fire),
        .val_i    (cur_q.wd_val),
        .expire_o (wd_fire)
    );

    // Pick the parameter set addressed by the read source
    always_comb begin
        src_set = cur_q;
        case (ASrc)
            ISrcCur:   src_set = cur_q;
            ISrcPrev1: src_set = prev1_q;
            ISrcInput: src_set = inp_q;
            ISrcPrev2: src_set = prev2_q;
            default:   src_set = cur_q;
        endcase
    end

    // Next state: set history shifts, staged writes, busy timer, read data, pending flag
    always_comb begin
        cur_d      = cur_q;
        prev1_d    = prev1_q;
        prev2_d    = prev2_q;
        inp_d      = inp_q;
        busy_cnt_d = idle ? 4'd0 : busy_cnt_q - 4'd1;
        data_out_d = data_out_q;
        pend_d     = pend_q | recfg_rise;

        if (wd_fire) begin
            prev2_d    = prev1_q;
            prev1_d    = cur_q;
            cur_d      = factory_set(CBootAddrFact, CCauseWd);
            busy_cnt_d = BusyLat;
            pend_d     = 1'b0;
        end else if (user_fire) begin
            prev2_d    = prev1_q;
            prev1_d    = cur_q;
            cur_d      = inp_q;
            cur_d.mode = CModeApp;
            cur_d.cause = CCauseUser;
            busy_cnt_d = BusyLat;
            pend_d     = 1'b0;
        end else if (wr_go) begin
            busy_cnt_d = BusyLat;
            case (AParam)
                IParWdVal: inp_d.wd_val = ADataIn[11:0];
                IParWdEn:  inp_d.wd_en  = ADataIn[0];
                IParAddr:  inp_d.addr   = ADataIn;
                IParMode:  inp_d.mode   = ADataIn[1:0];
                default:   inp_d        = inp_q;
            endcase
        end else if (rd_go) begin
            busy_cnt_d = BusyLat;
            data_out_d = field_read(src_set, AParam);
        end
    end

    // State registers and registered outputs
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            cur_q        <= factory_set(CBootAddrFact, 5'd0);
            prev1_q      <= factory_set(CBootAddrFact, 5'd0);
            prev2_q      <= factory_set(CBootAddrFact, 5'd0);
            inp_q        <= factory_set(CBootAddrFact, 5'd0);
            busy_cnt_q   <= 4'd0;
            pend_q       <= 1'b0;
            recfg_prev_q <= 1'b0;
            data_out_q   <= 32'd0;
            req_q        <= 1'b0;
            wdto_q       <= 1'b0;
            boot_addr_q  <= CBootAddrFact;
        end else begin
            cur_q        <= cur_d;
            prev1_q      <= prev1_d;
            prev2_q      <= prev2_d;
            inp_q        <= inp_d;
            busy_cnt_q   <= busy_cnt_d;
            pend_q       <= pend_d;
            recfg_prev_q <= AReconfig;
            data_out_q   <= data_out_d;
            req_q        <= wd_fire | user_fire;
            wdto_q       <= wd_fire;
            boot_addr_q  <= cur_d.addr;
        end
    end

endmodule
